vga_code_queue: RTL and testbench

- Frame-synchronous colour-code source sitting directly upstream of the 800x600 VGA timing/pixel stage; drives its 24-bit code input ([23:12] left-half RGB444, [11:0] right-half RGB444).
- Producers push codes through a valid/ready handshake into a small FIFO.
- The block changes its output only at a vertical-sync falling edge and holds each code for a fixed number of frames, so the display never tears mid-frame.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_code_queue_if.sv | 15 +
 rtl/code_fifo.sv | 59 +++++
 rtl/vga_code_queue.sv | 84 ++++++++
 tb/tb_vga_code_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour-code path: code layout, 800x600 timing, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

    localparam int CODE_W  = 24;
    localparam int LEFT_HI = 23;
    localparam int LEFT_LO = 12;
    localparam int RIGHT_HI = 11;
    localparam int RIGHT_LO = 0;

    // 800x600 @ 72 Hz with a 50 MHz pixel clock
    localparam int H_DISPLAY = 800;
    localparam int H_FRONT   = 56;
    localparam int H_SYNC    = 120;
    localparam int H_BACK    = 64;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_DISPLAY = 600;
    localparam int V_FRONT   = 37;
    localparam int V_SYNC    = 6;
    localparam int V_BACK    = 23;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [11:0] code_left(input logic [CODE_W-1:0] c);
        return c[LEFT_HI:LEFT_LO];
    endfunction

    function automatic logic [11:0] code_right(input logic [CODE_W-1:0] c);
        return c[RIGHT_HI:RIGHT_LO];
    endfunction

endpackage

// File: rtl/vga_code_queue_if.sv
// Producer-side valid/ready bus carrying colour codes into the queue.
// Latency: n/a (wires only).
// Backpressure: in_ready low means the push is refused and in_data must be held.
interface vga_code_queue_if
    import vga_pkg::*;
#(
    parameter int W = CODE_W
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/code_fifo.sv
// Single-clock FIFO holding pending colour codes; head is the oldest entry.
// Latency: a push is visible at head/level on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module code_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Occupancy follows push/pop; simultaneous push and pop cancel out
    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage array needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/vga_code_queue.sv
// Frame-synchronous colour-code source: queues codes and changes output only at vsync falls.
// Latency: code changes on the edge where vsync is first sampled low; each code held FRAMES_PER_CODE frames.
// Backpressure: in_ready drops when the FIFO is full, decoded from registered occupancy only.
module vga_code_queue
    import vga_pkg::*;
#(
    parameter int                DEPTH           = 4,
    parameter int                FRAMES_PER_CODE = 72,
    parameter logic [CODE_W-1:0] RESET_CODE      = 24'h000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_code_queue_if.slave        in_if,
    input  logic                   vsync_i,
    output logic [CODE_W-1:0]      code_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o
);
    localparam int CNT_W = (FRAMES_PER_CODE > 1) ? $clog2(FRAMES_PER_CODE) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              vsync_q;
    logic              tick, last_frame, push, pop;
    logic              fifo_full, fifo_empty;
    logic [CODE_W-1:0] fifo_head;

    assign tick       = vsync_q && !vsync_i;
    assign last_frame = (frame_cnt_q == CNT_W'(FRAMES_PER_CODE - 1));
    assign push       = in_if.in_valid && !fifo_full;
    assign pop        = tick && !fifo_empty && ((state_q == ST_IDLE) || last_frame);

    assign in_if.in_ready = !fifo_full;
    assign code_o         = code_q;
    assign busy_o         = (state_q == ST_HOLD);

    code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_if.in_data),
        .head_o  (fifo_head),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: only a frame tick can load a new code or advance the frame count
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        code_d      = code_q;
        if (tick) begin
            if (pop) begin
                code_d      = fifo_head;
                frame_cnt_d = '0;
                state_d     = ST_HOLD;
            end else if (state_q == ST_HOLD) begin
                if (last_frame) state_d = ST_IDLE;
                else            frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // State, counter, output code and vsync history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            code_q      <= RESET_CODE;
            vsync_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            code_q      <= code_d;
            vsync_q     <= vsync_i;
        end
    end
endmodule

// File: tb/tb_vga_code_queue.sv
// Self-checking bench for vga_code_queue: directed vector table, hand corner cases, random vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_code_queue;
    localparam int DEPTH = 4;
    localparam int FPC   = 2;
    localparam logic [23:0] RST_CODE = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic [23:0] code;
    logic [2:0]  level;
    logic        busy;

    vga_code_queue_if #(.W(24)) in_if ();

    vga_code_queue #(
        .DEPTH           (DEPTH),
        .FRAMES_PER_CODE (FPC),
        .RESET_CODE      (RST_CODE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_if   (in_if),
        .vsync_i (vsync),
        .code_o  (code),
        .level_o (level),
        .busy_o  (busy)
    );

    always #10 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // Behavioural model: a queue of pending codes plus what is on screen
    logic [23:0] m_q[$];
    logic [23:0] m_code;
    bit          m_hold;
    int          m_frames;
    bit          m_vprev;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        vs;
        logic [23:0] ec;
        logic [2:0]  el;
        logic        eb;
        logic        er;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [23:0] d, logic vs,
                                logic [23:0] ec, logic [2:0] el, logic eb, logic er);
        vec_t r;
        r.v = v; r.d = d; r.vs = vs; r.ec = ec; r.el = el; r.eb = eb; r.er = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_code   = RST_CODE;
        m_hold   = 0;
        m_frames = 0;
        m_vprev  = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".code"},  {8'h0, code}, {8'h0, m_code});
        chk({tag, ".level"}, {29'h0, level}, m_q.size());
        chk({tag, ".busy"},  {31'h0, busy}, {31'h0, m_hold});
        chk({tag, ".ready"}, {31'h0, in_if.in_ready}, (m_q.size() < DEPTH) ? 1 : 0);
    endtask

    // One clock: drive inputs, advance the model by the frame rules, compare after the edge
    task automatic step(input logic v, input logic [23:0] d, input logic vs);
        bit tk, do_push;
        @(negedge clk);
        in_if.in_valid = v;
        in_if.in_data  = d;
        vsync          = vs;
        tk      = m_vprev && !vs;
        do_push = v && (m_q.size() < DEPTH);
        if (tk) begin
            if (m_q.size() > 0 && (!m_hold || m_frames == FPC - 1)) begin
                m_code   = m_q.pop_front();
                m_frames = 0;
                m_hold   = 1;
            end else if (m_hold) begin
                if (m_frames == FPC - 1) m_hold = 0;
                else                     m_frames++;
            end
        end
        if (do_push) m_q.push_back(d);
        m_vprev = vs;
        @(posedge clk);
        #1;
        nvec++;
        check_model("model");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        vsync = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        model_reset();
        do_reset();

        // Reset state, then three vsync falls with nothing queued
        chk("rst.code", {8'h0, code}, 32'h0);
        chk("rst.level", {29'h0, level}, 0);
        chk("rst.busy", {31'h0, busy}, 0);
        chk("rst.ready", {31'h0, in_if.in_ready}, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 24'h0, 0);
            step(0, 24'h0, 1);
            chk("idle_tick.code", {8'h0, code}, 32'h0);
            chk("idle_tick.busy", {31'h0, busy}, 0);
        end

        // Directed table: single code, A/B hold sequence, overfill by one
        tbl.push_back(mk(1, 24'hF0000F, 1, 24'h000000, 1, 0, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'h000000, 1, 0, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'hF0000F, 0, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'hF0000F, 0, 1, 1));
        tbl.push_back(mk(1, 24'h123456, 1, 24'hF0000F, 1, 1, 1));
        tbl.push_back(mk(1, 24'hABCDEF, 1, 24'hF0000F, 2, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'hF0000F, 2, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'hF0000F, 2, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'h123456, 1, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'h123456, 1, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'h123456, 1, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'h123456, 1, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'hABCDEF, 0, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'hABCDEF, 0, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'hABCDEF, 0, 1, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'hABCDEF, 0, 1, 1));
        tbl.push_back(mk(0, 24'h0,      0, 24'hABCDEF, 0, 0, 1));
        tbl.push_back(mk(0, 24'h0,      1, 24'hABCDEF, 0, 0, 1));
        tbl.push_back(mk(1, 24'h000001, 1, 24'hABCDEF, 1, 0, 1));
        tbl.push_back(mk(1, 24'h000002, 1, 24'hABCDEF, 2, 0, 1));
        tbl.push_back(mk(1, 24'h000003, 1, 24'hABCDEF, 3, 0, 1));
        tbl.push_back(mk(1, 24'h000004, 1, 24'hABCDEF, 4, 0, 0));
        tbl.push_back(mk(1, 24'h000005, 1, 24'hABCDEF, 4, 0, 0));
        tbl.push_back(mk(1, 24'h000005, 0, 24'h000001, 3, 1, 1));
        tbl.push_back(mk(1, 24'h000005, 1, 24'h000001, 4, 1, 0));
        tbl.push_back(mk(0, 24'h0,      1, 24'h000001, 4, 1, 0));
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].vs);
            chk($sformatf("tbl%0d.code", i),  {8'h0, code}, {8'h0, tbl[i].ec});
            chk($sformatf("tbl%0d.level", i), {29'h0, level}, {29'h0, tbl[i].el});
            chk($sformatf("tbl%0d.busy", i),  {31'h0, busy}, {31'h0, tbl[i].eb});
            chk($sformatf("tbl%0d.ready", i), {31'h0, in_if.in_ready}, {31'h0, tbl[i].er});
        end

        // Push coincident with the final-frame tick: pop and push on one edge
        do_reset();
        step(1, 24'h111111, 1);
        step(1, 24'h222222, 1);
        step(0, 24'h0, 0);
        step(1, 24'h333333, 1);
        step(0, 24'h0, 0);
        step(0, 24'h0, 1);
        chk("pp.pre_level", {29'h0, level}, 2);
        step(1, 24'h444444, 0);
        chk("pp.level", {29'h0, level}, 2);
        chk("pp.code", {8'h0, code}, 32'h00222222);
        chk("pp.busy", {31'h0, busy}, 1);

        // Asynchronous reset mid-frame while holding with three queued
        step(1, 24'h555555, 1);
        chk("ar.pre_level", {29'h0, level}, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.code", {8'h0, code}, {8'h0, RST_CODE});
        chk("ar.level", {29'h0, level}, 0);
        chk("ar.busy", {31'h0, busy}, 0);
        chk("ar.ready", {31'h0, in_if.in_ready}, 1);
        model_reset();
        in_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 24'h0, 0);
        chk("ar.tick_code", {8'h0, code}, {8'h0, RST_CODE});
        chk("ar.tick_level", {29'h0, level}, 0);
        step(0, 24'h0, 1);

        // Random traffic against the queue model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1) == 1, 24'($urandom), $urandom_range(0, 7) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
